// File: rtl/audio_deserializer.sv
// Serial-to-parallel audio receiver. It generates the bit clock for the source, samples MSB-first
// and hands completed words to the consumer through valid/ack, with a sticky overrun flag.
module audio_deserializer #(
   parameter int WORD_LENGTH        = 16,
   parameter int SYSTEM_FREQUENCY   = 100000000,
   parameter int SAMPLING_FREQUENCY = 1000000
) (
   input  logic                   clock_i,
   input  logic                   reset_n_i,
   input  logic                   enable_i,
   input  logic                   serial_i,
   output logic                   bit_clock_o,
   output logic [WORD_LENGTH-1:0] Data_o,
   output logic                   valid_o,
   input  logic                   ack_i,
   output logic                   overrun_o
);

   localparam int DIVIDE = SYSTEM_FREQUENCY / SAMPLING_FREQUENCY;
   localparam int HALF   = DIVIDE / 2;
   localparam int DIV_W  = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
   localparam int BIT_W  = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                 state_r, state_s;
   logic [DIV_W-1:0]       div_cnt_r, div_cnt_s;
   logic [BIT_W-1:0]       bit_cnt_r, bit_cnt_s;
   logic [WORD_LENGTH-1:0] shift_r, shift_s;
   logic [WORD_LENGTH-1:0] data_r, data_s;
   logic                   valid_r, valid_s;
   logic                   overrun_r, overrun_s;
   logic                   bit_clock_r, bit_clock_s;
   logic                   complete_s;

   // Next-state, bit-timing and handshake decode.
   always_comb begin
      state_s     = state_r;
      div_cnt_s   = div_cnt_r;
      bit_cnt_s   = bit_cnt_r;
      shift_s     = shift_r;
      data_s      = data_r;
      valid_s     = valid_r;
      overrun_s   = overrun_r;
      complete_s  = 1'b0;
      bit_clock_s = 1'b0;

      case (enable_i)
         1'b1: begin
            state_s = SHIFT;
            if (div_cnt_r == DIV_W'(DIVIDE - 1)) begin
               div_cnt_s = '0;
            end else begin
               div_cnt_s = div_cnt_r + DIV_W'(1);
            end
            // The last high-phase cycle is the sample point; the source launched on the rising edge.
            if (div_cnt_r == DIV_W'(HALF - 1)) begin
               shift_s = {shift_r[WORD_LENGTH-2:0], serial_i};
               if (bit_cnt_r == BIT_W'(WORD_LENGTH - 1)) begin
                  bit_cnt_s  = '0;
                  complete_s = 1'b1;
               end else begin
                  bit_cnt_s = bit_cnt_r + BIT_W'(1);
               end
            end else begin
               shift_s = shift_r;
            end
         end
         default: begin
            state_s   = IDLE;
            div_cnt_s = '0;
            bit_cnt_s = '0;
            shift_s   = '0;
         end
      endcase

      if (ack_i && valid_r) begin
         valid_s = 1'b0;
      end else begin
         valid_s = valid_r;
      end

      // A word landing on an unacked word is an overrun unless that same edge consumes it.
      if (complete_s) begin
         data_s  = {shift_r[WORD_LENGTH-2:0], serial_i};
         valid_s = 1'b1;
         if (valid_r && !ack_i) begin
            overrun_s = 1'b1;
         end else begin
            overrun_s = overrun_r;
         end
      end else begin
         data_s = data_r;
      end

      if ((state_s == SHIFT) && (div_cnt_s < DIV_W'(HALF))) begin
         bit_clock_s = 1'b1;
      end else begin
         bit_clock_s = 1'b0;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_r     <= IDLE;
         div_cnt_r   <= '0;
         bit_cnt_r   <= '0;
         shift_r     <= '0;
         data_r      <= '0;
         valid_r     <= 1'b0;
         overrun_r   <= 1'b0;
         bit_clock_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         div_cnt_r   <= div_cnt_s;
         bit_cnt_r   <= bit_cnt_s;
         shift_r     <= shift_s;
         data_r      <= data_s;
         valid_r     <= valid_s;
         overrun_r   <= overrun_s;
         bit_clock_r <= bit_clock_s;
      end
   end

   assign bit_clock_o = bit_clock_r;
   assign Data_o      = data_r;
   assign valid_o     = valid_r;
   assign overrun_o   = overrun_r;

endmodule

// File: tb/tb_audio_deserializer.sv
// Directed self-checking bench for audio_deserializer with DIVIDE=8, HALF=4 and 16-bit words.
module tb_audio_deserializer;

   logic        clock_i;
   logic        reset_n_i;
   logic        enable_i;
   logic        serial_i;
   logic        bit_clock_o;
   logic [15:0] Data_o;
   logic        valid_o;
   logic        ack_i;
   logic        overrun_o;

   int          checks_cnt = 0;
   int          errors_cnt = 0;
   int          edge_n     = 0;
   logic [63:0] stream_r   = 64'h0;

   audio_deserializer #(
      .WORD_LENGTH       (16),
      .SYSTEM_FREQUENCY  (8),
      .SAMPLING_FREQUENCY(1)
   ) dut (
      .clock_i    (clock_i),
      .reset_n_i  (reset_n_i),
      .enable_i   (enable_i),
      .serial_i   (serial_i),
      .bit_clock_o(bit_clock_o),
      .Data_o     (Data_o),
      .valid_o    (valid_o),
      .ack_i      (ack_i),
      .overrun_o  (overrun_o)
   );

   initial clock_i = 1'b0;
   always #5 clock_i = ~clock_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, edge_n - 1);
      end
   endtask

   // One rising edge; edge_n then holds the index of the next enabled edge.
   task automatic step();
      int k;
      @(posedge clock_i);
      if (enable_i) edge_n++;
      #1;
      k = edge_n / 8;
      serial_i = (k < 64) ? stream_r[63 - k] : 1'b0;
   endtask

   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (edge_n < target + 1 && guard < 2000) begin
         step();
         guard++;
      end
      if (guard >= 2000) check("run_to_timeout", 32'(edge_n), 32'(target + 1));
   endtask

   task automatic start(input logic [63:0] s);
      stream_r = s;
      edge_n   = 0;
      enable_i = 1'b1;
      serial_i = s[63];
   endtask

   task automatic stop();
      enable_i = 1'b0;
      step();
   endtask

   task automatic ack_pulse();
      ack_i = 1'b1;
      step();
      ack_i = 1'b0;
   endtask

   initial begin
      reset_n_i = 1'b0;
      enable_i  = 1'b1;
      serial_i  = 1'b1;
      ack_i     = 1'b0;
      stream_r  = {64{1'b1}};
      repeat (3) step();
      check("rst_data", 32'(Data_o), 32'h0000);
      check("rst_valid", 32'(valid_o), 32'h0);
      check("rst_overrun", 32'(overrun_o), 32'h0);
      check("rst_bclk", 32'(bit_clock_o), 32'h0);
      enable_i  = 1'b0;
      reset_n_i = 1'b1;
      step();
      check("idle_bclk", 32'(bit_clock_o), 32'h0);

      // Single word with bit-clock shape and ack.
      start({16'hA5C3, 48'h0});
      run_to(7);
      for (int i = 0; i < 8; i++) begin
         check("bclk_shape", 32'(bit_clock_o), (i < 4) ? 32'h1 : 32'h0);
         step();
      end
      run_to(122);
      check("single_valid_early", 32'(valid_o), 32'h0);
      run_to(123);
      check("single_valid", 32'(valid_o), 32'h1);
      check("single_data", 32'(Data_o), 32'hA5C3);
      run_to(129);
      check("single_hold", 32'(valid_o), 32'h1);
      ack_pulse();
      check("single_ack", 32'(valid_o), 32'h0);
      check("single_ovr", 32'(overrun_o), 32'h0);
      stop();
      check("stop_bclk", 32'(bit_clock_o), 32'h0);

      // Back-to-back with timely ack.
      start({16'h1234, 16'hFFFF, 32'h0});
      run_to(123);
      check("b2b_data1", 32'(Data_o), 32'h1234);
      check("b2b_valid1", 32'(valid_o), 32'h1);
      ack_pulse();
      check("b2b_ack1", 32'(valid_o), 32'h0);
      run_to(251);
      check("b2b_data2", 32'(Data_o), 32'hFFFF);
      check("b2b_valid2", 32'(valid_o), 32'h1);
      check("b2b_ovr", 32'(overrun_o), 32'h0);
      ack_pulse();
      check("b2b_ack2", 32'(valid_o), 32'h0);
      stop();

      // Overrun: second word lands on an unacked one.
      start({16'h0001, 16'h8000, 32'h0});
      run_to(123);
      check("ovr_data1", 32'(Data_o), 32'h0001);
      run_to(250);
      check("ovr_before", 32'(overrun_o), 32'h0);
      run_to(251);
      check("ovr_data2", 32'(Data_o), 32'h8000);
      check("ovr_valid", 32'(valid_o), 32'h1);
      check("ovr_flag", 32'(overrun_o), 32'h1);
      ack_pulse();
      check("ovr_ack_valid", 32'(valid_o), 32'h0);
      check("ovr_sticky", 32'(overrun_o), 32'h1);
      stop();
      check("ovr_sticky_idle", 32'(overrun_o), 32'h1);
      reset_n_i = 1'b0;
      step();
      reset_n_i = 1'b1;
      step();
      check("ovr_cleared", 32'(overrun_o), 32'h0);
      check("ovr_rst_data", 32'(Data_o), 32'h0000);

      // Ack on the very edge the next word completes.
      start({16'h0F0F, 16'h3C3C, 32'h0});
      run_to(250);
      check("sim_valid1", 32'(valid_o), 32'h1);
      check("sim_data1", 32'(Data_o), 32'h0F0F);
      ack_pulse();
      check("sim_data2", 32'(Data_o), 32'h3C3C);
      check("sim_valid2", 32'(valid_o), 32'h1);
      check("sim_ovr", 32'(overrun_o), 32'h0);
      ack_pulse();
      check("sim_ack", 32'(valid_o), 32'h0);
      stop();

      // Abort after 7 bits, then a clean word.
      start({16'hFFFF, 48'h0});
      run_to(53);
      stop();
      check("abort_bclk0", 32'(bit_clock_o), 32'h0);
      repeat (5) step();
      check("abort_bclk1", 32'(bit_clock_o), 32'h0);
      check("abort_valid", 32'(valid_o), 32'h0);
      start({16'h5A5A, 48'h0});
      run_to(122);
      check("reen_valid_early", 32'(valid_o), 32'h0);
      run_to(123);
      check("reen_valid", 32'(valid_o), 32'h1);
      check("reen_data", 32'(Data_o), 32'h5A5A);
      check("reen_ovr", 32'(overrun_o), 32'h0);
      stop();

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/audio_deserializer.md
# audio_deserializer

Serial-to-parallel receiver for the audio path. Generates a bit clock for an external serial source (PDM microphone or loop-back from the serializer's output), samples the incoming bit stream MSB-first, and assembles `WORD_LENGTH`-bit words. Completed words are presented on `Data_o` with a valid/acknowledge handshake to the downstream sample consumer. A sticky overrun flag reports words that were lost.

## Interface
- `WORD_LENGTH`, default 16: bits per word; first received bit is the MSB.
- `SYSTEM_FREQUENCY`, default 100000000: `clock_i` frequency in Hz.
- `SAMPLING_FREQUENCY`, default 1000000: bit rate in Hz.
  - `DIVIDE` = `SYSTEM_FREQUENCY`/`SAMPLING_FREQUENCY` (integer). `DIVIDE` ≥ 2 is required.
  - `HALF` = `DIVIDE`/2 (floor).
- `clock_i` in 1: system clock. Every register is updated on its rising edge.
- `reset_n_i` in 1: synchronous, active-low reset.
- `enable_i` in 1: runs the receiver. When low, the receiver idles and any partial word is discarded.
- `serial_i` in 1: serial data from the source. It is already synchronous to `clock_i`.
- `bit_clock_o` out 1: bit clock driven to the source.
- `Data_o` out `WORD_LENGTH`: the last completed word.
- `valid_o` out 1: `Data_o` holds an unconsumed word.
- `ack_i` in 1: the consumer takes the word while `valid_o` is high.
- `overrun_o` out 1: sticky flag; a completed word overwrote an unacknowledged one.

## Operation
- Reset (`reset_n_i` low at an edge) clears all state:
  - `div_cnt` = 0, `bit_cnt` = 0, shift register = 0.
  - `Data_o` = 0, `valid_o` = 0, `overrun_o` = 0, `bit_clock_o` = 0.
  - Reset overrides every other input.
- States: IDLE (`enable_i` low) and SHIFT (`enable_i` high).
- IDLE:
  - `div_cnt` and `bit_cnt` are held at 0 and the partial shift contents are discarded.
  - `Data_o`, `valid_o` and `overrun_o` keep their values.
  - `ack_i` handling still applies.
- SHIFT:
  - `div_cnt` counts 0…`DIVIDE`-1 and wraps to 0.
  - `bit_clock_o` = 1 while `div_cnt` < `HALF`, otherwise 0. It is decoded from registered `div_cnt` and the registered run state. It is 0 in IDLE.
- Sample edge: the edge at which `div_cnt` == `HALF`-1 (the last high-phase cycle).
  - `serial_i` shifts into the LSB of the shift register.
  - `bit_cnt` increments.
- On the sample edge where `bit_cnt` == `WORD_LENGTH`-1:
  - `Data_o` ← {shift[`WORD_LENGTH`-2:0], `serial_i`}.
  - `valid_o` ← 1.
  - `bit_cnt` ← 0.
  - The next word starts immediately with no gap.
- Handshake:
  - `ack_i` high while `valid_o` = 1 clears `valid_o` at that edge.
  - `ack_i` while `valid_o` = 0 is ignored.
- Word completes in the same edge as `ack_i` with `valid_o` = 1: the new word loads, `valid_o` stays 1, and there is no overrun (the old word was consumed).
- Word completes with `valid_o` = 1 and no `ack_i`: `Data_o` is overwritten, `valid_o` stays 1, and `overrun_o` ← 1.
- `overrun_o` clears only on reset.
- `enable_i` falls mid-word: the partial word is dropped. On re-enable, counting restarts at bit 0 and `div_cnt` 0.

## Timing
- Edges are numbered from the first edge at which `enable_i` is sampled high (edge 0, where `div_cnt` 0→1).
- Bit k is sampled at edge `DIVIDE`·k + `HALF`-1.
- `valid_o` and `Data_o` change at the edge `DIVIDE`·(`WORD_LENGTH`-1) + `HALF`-1. There is no additional pipeline latency.
- Subsequent words complete every `DIVIDE`·`WORD_LENGTH` cycles.
- `valid_o` falls at the edge that samples `ack_i` high. Earliest re-assert is the next word completion.
- `serial_i` must be stable on the sample edge. The source launches data on the rising edge of `bit_clock_o`.

## Test plan
- Bench parameters for all tests: `SYSTEM_FREQUENCY`=8, `SAMPLING_FREQUENCY`=1 (`DIVIDE`=8, `HALF`=4), `WORD_LENGTH`=16.
- Reset: hold `reset_n_i` low for 3 cycles with `enable_i`=1 and `serial_i`=1 -> `Data_o`=0x0000, `valid_o`=0, `overrun_o`=0, `bit_clock_o`=0.
- Single word: drive 0xA5C3 MSB-first, each bit stable around edge 8k+3 -> `bit_clock_o` is 4 cycles high / 4 low; `valid_o` rises at edge 123 with `Data_o`=0xA5C3; `ack_i` pulsed at edge 130 -> `valid_o`=0 after edge 130.
- Back-to-back with timely ack: send 0x1234 then 0xFFFF, acking each within 8 cycles -> `Data_o`=0x1234 at edge 123, `Data_o`=0xFFFF at edge 251, `overrun_o` stays 0.
- Overrun: send 0x0001 then 0x8000 with no `ack_i` -> at edge 251 `Data_o`=0x8000, `valid_o`=1, `overrun_o`=1; `overrun_o` holds through later acks until reset.
- Simultaneous ack and completion: hold `valid_o`=1 from word 1 and assert `ack_i` exactly at edge 251 -> `Data_o`=word 2, `valid_o`=1, `overrun_o`=0.
- Abort mid-word: drop `enable_i` after 7 bits, then re-enable and send 0x5A5A -> `bit_clock_o`=0 while idle; the first completion after re-enable carries 0x5A5A, with no bits from the aborted word.
